// File: rtl/xy_scan_gen.sv
// -----------------------------------------------------------------------------
// xy_scan_gen
//
// Two-dimensional pixel address generator. After a start request it scans
// every pixel of an (X_MAX+1) x (Y_MAX+1) frame in raster order. The address
// advances by one pixel on each accepted beat, which is a SCAN cycle with
// enable=1. The renderer tracks the scan through a start/busy/done handshake.
//
// Optional feature macro: XY_SCAN_SERPENTINE_EN
//   defined   -> serpentine order. Even rows run 0..X_MAX and odd rows run
//                X_MAX..0.
//   undefined -> every row runs 0..X_MAX.
//
// Parameters
//   X_WIDTH, Y_WIDTH : address widths
//   X_MAX, Y_MAX     : last X of a line / last Y of a frame (inclusive)
//
// Ports
//   clock     : rising-edge clock
//   reset     : synchronous, active-high reset
//   start     : begin a frame scan (sampled only in IDLE)
//   enable    : advance strobe; the current pixel is accepted when valid && enable
//   abort     : leave SCAN for IDLE without a done pulse (wins over enable)
//   x_addr    : current pixel X (registered)
//   y_addr    : current pixel Y (registered)
//   valid     : address holds a pixel of the active frame
//   line_end  : valid && current pixel is the last one of its row
//   frame_end : valid && current pixel is the last one of the frame
//   busy      : high while scanning
//   done      : one-cycle pulse after the final pixel is accepted
// -----------------------------------------------------------------------------
module xy_scan_gen #(
   parameter int X_WIDTH = 8,
   parameter int Y_WIDTH = 8,
   parameter int X_MAX   = 159,
   parameter int Y_MAX   = 119
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               enable,
   input  logic               abort,
   output logic [X_WIDTH-1:0] x_addr,
   output logic [Y_WIDTH-1:0] y_addr,
   output logic               valid,
   output logic               line_end,
   output logic               frame_end,
   output logic               busy,
   output logic               done
);

   // Reject limits that do not fit in the counters.
   if (X_MAX >= (1 << X_WIDTH)) begin : g_bad_x_max
      $error("xy_scan_gen: X_MAX does not fit in X_WIDTH bits");
   end
   if (Y_MAX >= (1 << Y_WIDTH)) begin : g_bad_y_max
      $error("xy_scan_gen: Y_MAX does not fit in Y_WIDTH bits");
   end

   localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(X_MAX);
   localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(Y_MAX);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [X_WIDTH-1:0] x_next;
   logic [Y_WIDTH-1:0] y_next;

   // Row geometry: the last X of the current row, the first X of the next row,
   // and the X of the next pixel in the current row.
   logic [X_WIDTH-1:0] row_last_x;
   logic [X_WIDTH-1:0] next_row_first_x;
   logic [X_WIDTH-1:0] x_step;
   logic               at_line_end;
   logic               at_frame_end;

`ifdef XY_SCAN_SERPENTINE_EN
   // An odd row (y[0]=1) runs right to left. The row after an even row is
   // odd, so it starts at X_LAST.
   assign row_last_x       = y_addr[0] ? '0 : X_LAST;
   assign next_row_first_x = y_addr[0] ? '0 : X_LAST;
   assign x_step           = y_addr[0] ? x_addr - X_WIDTH'(1) : x_addr + X_WIDTH'(1);
`else
   assign row_last_x       = X_LAST;
   assign next_row_first_x = '0;
   assign x_step           = x_addr + X_WIDTH'(1);
`endif

   // Equality compares only, so a counter never steps past its limit, even
   // when the limit is the all-ones value of the counter.
   assign at_line_end  = (x_addr == row_last_x);
   assign at_frame_end = at_line_end && (y_addr == Y_LAST);

   // NOTE: every signal written in this block gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      x_next     = x_addr;
      y_next     = y_addr;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_next = SCAN;
               x_next     = '0;
               y_next     = '0;
            end
         end
         SCAN: begin
            if (abort) begin
               state_next = IDLE;
               x_next     = '0;
               y_next     = '0;
            end else if (enable) begin
               if (at_frame_end) begin
                  state_next = DONE;
                  x_next     = '0;
                  y_next     = '0;
               end else if (at_line_end) begin
                  x_next = next_row_first_x;
                  y_next = y_addr + Y_WIDTH'(1);
               end else begin
                  x_next = x_step;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
            x_next     = '0;
            y_next     = '0;
         end
         default: begin
            state_next = IDLE;
            x_next     = '0;
            y_next     = '0;
         end
      endcase
   end

   // valid/busy/done are flops loaded from the next state, so the only
   // combinational outputs are line_end and frame_end.
   // NOTE: sequential state uses non-blocking assignments, so every flop
   // samples values from before the edge regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         x_addr <= '0;
         y_addr <= '0;
         valid  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_next;
         x_addr <= x_next;
         y_addr <= y_next;
         valid  <= (state_next == SCAN);
         busy   <= (state_next == SCAN);
         done   <= (state_next == DONE);
      end
   end

   assign line_end  = valid && at_line_end;
   assign frame_end = valid && at_frame_end;

endmodule

// File: tb/tb_xy_scan_gen.sv
// -----------------------------------------------------------------------------
// tb_xy_scan_gen
//
// Self-checking bench for xy_scan_gen. The main instance uses a 4x3 frame with
// 8-bit counters. A second instance uses a 4x2 frame whose counters are
// exactly wide enough for the limits, and it covers the short and serpentine
// frame. The expected pixel order comes from a list of pixels built from the
// scan rules. Enable and start are randomized. Each check compares all
// outputs as one packed word at the falling edge.
// -----------------------------------------------------------------------------
module tb_xy_scan_gen;

`ifdef XY_SCAN_SERPENTINE_EN
   localparam bit SERP = 1'b1;
`else
   localparam bit SERP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Shared controls. The second instance has its own start/enable.
   logic reset  = 1'b1;
   logic start  = 1'b0;
   logic enable = 1'b0;
   logic abort  = 1'b0;
   logic start2  = 1'b0;
   logic enable2 = 1'b0;

   logic [7:0] x_addr;
   logic [7:0] y_addr;
   logic       valid, line_end, frame_end, busy, done;

   logic [1:0] x2;
   logic [0:0] y2;
   logic       valid2, line_end2, frame_end2, busy2, done2;

   xy_scan_gen #(.X_WIDTH(8), .Y_WIDTH(8), .X_MAX(3), .Y_MAX(2)) dut (
      .clock(clk), .reset(reset), .start(start), .enable(enable), .abort(abort),
      .x_addr(x_addr), .y_addr(y_addr), .valid(valid), .line_end(line_end),
      .frame_end(frame_end), .busy(busy), .done(done)
   );

   xy_scan_gen #(.X_WIDTH(2), .Y_WIDTH(1), .X_MAX(3), .Y_MAX(1)) dut2 (
      .clock(clk), .reset(reset), .start(start2), .enable(enable2), .abort(abort),
      .x_addr(x2), .y_addr(y2), .valid(valid2), .line_end(line_end2),
      .frame_end(frame_end2), .busy(busy2), .done(done2)
   );

   int checks = 0;
   int errors = 0;

   // Observed words: {x, y, valid, busy, line_end, frame_end, done}
   logic [20:0] obs1;
   logic [7:0]  obs2;
   assign obs1 = {x_addr, y_addr, valid, busy, line_end, frame_end, done};
   assign obs2 = {x2, y2, valid2, busy2, line_end2, frame_end2, done2};

   function automatic logic [20:0] pack1(int x, int y, bit v, bit b, bit le, bit fe, bit d);
      return {8'(x), 8'(y), v, b, le, fe, d};
   endfunction

   function automatic logic [7:0] pack2(int x, int y, bit v, bit b, bit le, bit fe, bit d);
      return {2'(x), 1'(y), v, b, le, fe, d};
   endfunction

   // Expected pixel order for one frame.
   int e_x[$];
   int e_y[$];
   bit e_le[$];
   bit e_fe[$];

   function automatic void build_seq(int xmax, int ymax);
      e_x.delete(); e_y.delete(); e_le.delete(); e_fe.delete();
      for (int y = 0; y <= ymax; y++) begin
         for (int k = 0; k <= xmax; k++) begin
            e_x.push_back((SERP && (y % 2 == 1)) ? xmax - k : k);
            e_y.push_back(y);
            e_le.push_back(k == xmax);
            e_fe.push_back((k == xmax) && (y == ymax));
         end
      end
   endfunction

   function automatic int find_pixel(int x, int y);
      for (int i = 0; i < e_x.size(); i++)
         if (e_x[i] == x && e_y[i] == y) return i;
      return 0;
   endfunction

   logic [20:0] exp1;
   logic [7:0]  exp2;

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      start = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         exp1 = pack1(0, 0, 0, 0, 0, 0, 0);
         if (obs1 !== exp1) begin
            errors++;
            $display("FAIL reset_hold[%0d]: got %h want %h", c, obs1, exp1);
         end
      end
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (obs1 !== exp1) begin
         errors++;
         $display("FAIL reset_release: got %h want %h", obs1, exp1);
      end
      checks++;
      exp2 = pack2(0, 0, 0, 0, 0, 0, 0);
      if (obs2 !== exp2) begin
         errors++;
         $display("FAIL reset_dut2: got %h want %h", obs2, exp2);
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_full_raster();
      build_seq(3, 2);
      enable = 1'b1;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < e_x.size(); i++) begin
         checks++;
         exp1 = pack1(e_x[i], e_y[i], 1, 1, e_le[i], e_fe[i], 0);
         if (obs1 !== exp1) begin
            errors++;
            $display("FAIL raster_pixel[%0d]: got %h want %h", i, obs1, exp1);
         end
         @(negedge clk);
      end
      enable = 1'b0;
      checks++;
      exp1 = pack1(0, 0, 0, 0, 0, 0, 1);
      if (obs1 !== exp1) begin
         errors++;
         $display("FAIL raster_done: got %h want %h", obs1, exp1);
      end
      @(negedge clk);
      checks++;
      exp1 = pack1(0, 0, 0, 0, 0, 0, 0);
      if (obs1 !== exp1) begin
         errors++;
         $display("FAIL raster_idle_after: got %h want %h", obs1, exp1);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Random stall pattern (first four beats 1,0,0,1) with random start pulses
   // during SCAN. A start during DONE must also be ignored.
   task automatic test_stall();
      bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int idx = 0;
      int cyc = 0;
      build_seq(3, 2);
      start = 1'b1;
      @(negedge clk);
      while (idx < e_x.size() && cyc < 300) begin
         checks++;
         exp1 = pack1(e_x[idx], e_y[idx], 1, 1, e_le[idx], e_fe[idx], 0);
         if (obs1 !== exp1) begin
            errors++;
            $display("FAIL stall_pixel[cyc %0d]: got %h want %h", cyc, obs1, exp1);
         end
         enable = (cyc < 4) ? pat[cyc] : 1'($urandom_range(0, 1));
         start  = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (enable) idx++;
         cyc++;
      end
      enable = 1'b0;
      if (idx < e_x.size()) begin
         checks++;
         errors++;
         $display("FAIL stall_timeout: accepted %0d want %0d", idx, e_x.size());
      end
      checks++;
      exp1 = pack1(0, 0, 0, 0, 0, 0, 1);
      if (obs1 !== exp1) begin
         errors++;
         $display("FAIL stall_done: got %h want %h", obs1, exp1);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      exp1 = pack1(0, 0, 0, 0, 0, 0, 0);
      if (obs1 !== exp1) begin
         errors++;
         $display("FAIL start_in_done_ignored: got %h want %h", obs1, exp1);
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_abort();
      int target;
      int idx = 0;
      int cyc = 0;
      build_seq(3, 2);
      target = find_pixel(2, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (idx < target && cyc < 200) begin
         checks++;
         exp1 = pack1(e_x[idx], e_y[idx], 1, 1, e_le[idx], e_fe[idx], 0);
         if (obs1 !== exp1) begin
            errors++;
            $display("FAIL abort_pixel[cyc %0d]: got %h want %h", cyc, obs1, exp1);
         end
         enable = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (enable) idx++;
         cyc++;
      end
      checks++;
      exp1 = pack1(e_x[target], e_y[target], 1, 1, e_le[target], e_fe[target], 0);
      if (obs1 !== exp1) begin
         errors++;
         $display("FAIL abort_at_target: got %h want %h", obs1, exp1);
      end
      abort  = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      abort  = 1'b0;
      enable = 1'b0;
      checks++;
      exp1 = pack1(0, 0, 0, 0, 0, 0, 0);
      if (obs1 !== exp1) begin
         errors++;
         $display("FAIL abort_to_idle: got %h want %h", obs1, exp1);
      end
      @(negedge clk);
      checks++;
      if (obs1 !== exp1) begin
         errors++;
         $display("FAIL abort_no_done: got %h want %h", obs1, exp1);
      end
      // abort is ignored in IDLE, so a simultaneous start still launches.
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      checks++;
      exp1 = pack1(e_x[0], e_y[0], 1, 1, e_le[0], e_fe[0], 0);
      if (obs1 !== exp1) begin
         errors++;
         $display("FAIL abort_restart: got %h want %h", obs1, exp1);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset_mid_scan();
      int target;
      int idx = 0;
      int cyc = 0;
      build_seq(3, 2);
      target = find_pixel(1, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (idx < target && cyc < 200) begin
         enable = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (enable) idx++;
         cyc++;
      end
      checks++;
      exp1 = pack1(e_x[target], e_y[target], 1, 1, e_le[target], e_fe[target], 0);
      if (obs1 !== exp1) begin
         errors++;
         $display("FAIL reset_mid_target: got %h want %h", obs1, exp1);
      end
      reset  = 1'b1;
      enable = 1'($urandom_range(0, 1));
      @(negedge clk);
      reset  = 1'b0;
      enable = 1'b0;
      checks++;
      exp1 = pack1(0, 0, 0, 0, 0, 0, 0);
      if (obs1 !== exp1) begin
         errors++;
         $display("FAIL reset_mid_zero: got %h want %h", obs1, exp1);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      exp1 = pack1(e_x[0], e_y[0], 1, 1, e_le[0], e_fe[0], 0);
      if (obs1 !== exp1) begin
         errors++;
         $display("FAIL reset_mid_restart: got %h want %h", obs1, exp1);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Short frame on the instance with tight counter widths. This covers the
   // serpentine order when the macro is defined.
   task automatic test_serpentine();
      int idx = 0;
      int cyc = 0;
      build_seq(3, 1);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      while (idx < e_x.size() && cyc < 200) begin
         checks++;
         exp2 = pack2(e_x[idx], e_y[idx], 1, 1, e_le[idx], e_fe[idx], 0);
         if (obs2 !== exp2) begin
            errors++;
            $display("FAIL serp_pixel[cyc %0d]: got %h want %h", cyc, obs2, exp2);
         end
         enable2 = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (enable2) idx++;
         cyc++;
      end
      enable2 = 1'b0;
      if (idx < e_x.size()) begin
         checks++;
         errors++;
         $display("FAIL serp_timeout: accepted %0d want %0d", idx, e_x.size());
      end
      checks++;
      exp2 = pack2(0, 0, 0, 0, 0, 0, 1);
      if (obs2 !== exp2) begin
         errors++;
         $display("FAIL serp_done: got %h want %h", obs2, exp2);
      end
      @(negedge clk);
      checks++;
      exp2 = pack2(0, 0, 0, 0, 0, 0, 0);
      if (obs2 !== exp2) begin
         errors++;
         $display("FAIL serp_idle_after: got %h want %h", obs2, exp2);
      end
   endtask

   initial begin
      test_reset();
      test_full_raster();
      test_stall();
      test_abort();
      test_reset_mid_scan();
      test_serpentine();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
